artec_dma_ch_dispatch: RTL and testbench
========================================

ARTEC_DMA_CH_DISPATCH -- requirements
Module: artec_dma_ch_dispatch

Interface
REQ-001 SHALL have parameter CH_NUM, default artec_dma_pkg::PKG_CH_NUM, number of DMA channels (>=2).
REQ-002 SHALL have parameter REQ_WIDTH, default artec_dma_pkg::PKG_REQ_WIDTH, per-channel request field width (unsigned burst length in beats; 0 = no request).
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-004 SHALL have: clear  in  1  synchronous abort, active-high.
REQ-005 SHALL have: grant_i  in  $clog2(CH_NUM)  winning channel index from round-robin arbiter.
REQ-006 SHALL have: grant_valid_i  in  1  grant_i valid this cycle.
REQ-007 SHALL have: req_i  in  CH_NUM x REQ_WIDTH (packed [CH_NUM-1:0][REQ_WIDTH-1:0])  per-channel burst length, same vector the arbiter sees.
REQ-008 SHALL have: busy_o  out  1  dispatcher holding a grant; grants ignored.
REQ-009 SHALL have: cmd_valid_o  out  1 / cmd_ready_i  in  1  command handshake to datapath.
REQ-010 SHALL have: cmd_ch_o  out  $clog2(CH_NUM)  captured channel; cmd_len_o  out  REQ_WIDTH  captured length.
REQ-011 SHALL have: beat_valid_i  in  1 / beat_ready_o  out  1 / beat_last_o  out  1  data-beat handshake and last-beat flag.
REQ-012 SHALL have: done_o  out  CH_NUM  one-hot, one-cycle completion pulse per channel.
REQ-013 SHALL have: err_o  out  1  one-cycle pulse on rejected grant.

Function
REQ-014 SHALL implement FSM IDLE, CMD, DATA, DONE; busy_o = (state != IDLE).
REQ-015 IDLE: on grant_valid_i SHALL capture ch=grant_i, len=req_i[grant_i] into registers and enter CMD next cycle.
REQ-016 IDLE: grant with len==0 or grant_i>=CH_NUM SHALL pulse err_o next cycle, stay IDLE, capture nothing.
REQ-017 grant_valid_i outside IDLE SHALL be ignored (no capture, no err_o).
REQ-018 CMD: cmd_valid_o=1, cmd_ch_o/cmd_len_o stable until cmd_ready_i; transfer in cycle with valid&ready; next state DATA, beat counter=len.
REQ-019 cmd_valid_o SHALL rise exactly one cycle after the accepting grant cycle (latency 1).
REQ-020 DATA: beat_ready_o=1; each beat_valid_i&beat_ready_o decrements counter by 1; beat_last_o=1 when counter==1.
REQ-021 Last beat accepted (counter==1 and handshake) SHALL move to DONE; len=1 gives single-beat burst with beat_last_o on first beat.
REQ-022 DONE: done_o[ch]=1 for exactly one cycle, busy_o still 1; next state IDLE unconditionally.
REQ-023 New grant SHALL be accepted no earlier than two cycles after last beat (DONE, then IDLE).
REQ-024 cmd_valid_o, beat_ready_o, beat_last_o SHALL be 0 outside CMD/DATA respectively.
REQ-025 req_i changes after capture SHALL NOT affect cmd_len_o or counter.
REQ-026 clear SHALL have priority over all events: next cycle state IDLE, counter 0, no done_o, no err_o; grant in same cycle as clear dropped.
REQ-027 Counter width REQ_WIDTH, never underflows; max burst 2^REQ_WIDTH-1 beats.

Reset
REQ-028 rst asserted SHALL immediately force state IDLE and all outputs (busy_o, cmd_valid_o, cmd_ch_o, cmd_len_o, beat_ready_o, beat_last_o, done_o, err_o) to 0, including mid-burst.
REQ-029 First grant after rst deassertion SHALL be accepted on the first rising edge with rst low.

Verification
REQ-030 CH_NUM=4: req_i[2]=3, grant_i=2 valid 1 cycle, cmd_ready_i=1, beat_valid_i=1 -> cmd_valid_o next cycle with cmd_ch_o=2, cmd_len_o=3; 3 beats, beat_last_o on 3rd; done_o=4'b0100 one cycle.
REQ-031 cmd_ready_i low 5 cycles -> cmd_valid_o held, cmd_ch_o/cmd_len_o stable; req_i[2] changed to 7 meanwhile -> 3 beats still.
REQ-032 grant_i=1 with req_i[1]=0 -> err_o pulse, busy_o stays 0, no cmd_valid_o.
REQ-033 grant during DATA of ch0 (grant_i=3) -> ignored; after done_o=4'b0001, re-grant 3 accepted two cycles after last beat.
REQ-034 clear after 1 of 4 beats -> IDLE next cycle, done_o stays 0, busy_o 0; rst mid-CMD -> all outputs 0 immediately.

Source files
------------

// File: rtl/artec_dma_pkg.sv
// Shared constants for the ARTEC DMA channel blocks.
//   PKG_CH_NUM    : default number of DMA channels
//   PKG_REQ_WIDTH : default per-channel burst-length field width
package artec_dma_pkg;

   localparam int unsigned PKG_CH_NUM    = 4;
   localparam int unsigned PKG_REQ_WIDTH = 4;

endpackage

// File: rtl/artec_dma_ch_dispatch.sv
// DMA channel dispatcher: takes one arbiter grant at a time, captures the
// channel and burst length, issues a command to the datapath, counts the
// data beats and pulses a per-channel completion flag.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   clear            : synchronous abort back to IDLE
//   grant_i          : winning channel index from the arbiter
//   grant_valid_i    : grant_i valid this cycle
//   req_i            : per-channel burst length (0 = no request)
//   busy_o           : dispatcher holds a grant (grants ignored)
//   cmd_valid_o      : command valid toward datapath
//   cmd_ready_i      : datapath accepts command
//   cmd_ch_o         : captured channel
//   cmd_len_o        : captured burst length
//   beat_valid_i     : data beat offered
//   beat_ready_o     : dispatcher accepts data beats
//   beat_last_o      : current beat is the last of the burst
//   done_o           : one-hot, one-cycle completion pulse
//   err_o            : one-cycle pulse on a rejected grant
module artec_dma_ch_dispatch #(
   parameter int unsigned CH_NUM    = artec_dma_pkg::PKG_CH_NUM,
   parameter int unsigned REQ_WIDTH = artec_dma_pkg::PKG_REQ_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   input  logic [$clog2(CH_NUM)-1:0]           grant_i,
   input  logic                                grant_valid_i,
   input  logic [CH_NUM-1:0][REQ_WIDTH-1:0]    req_i,
   output logic                                busy_o,
   output logic                                cmd_valid_o,
   input  logic                                cmd_ready_i,
   output logic [$clog2(CH_NUM)-1:0]           cmd_ch_o,
   output logic [REQ_WIDTH-1:0]                cmd_len_o,
   input  logic                                beat_valid_i,
   output logic                                beat_ready_o,
   output logic                                beat_last_o,
   output logic [CH_NUM-1:0]                   done_o,
   output logic                                err_o
);

   localparam int unsigned CH_W = $clog2(CH_NUM);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state;
   logic [REQ_WIDTH-1:0] cnt;
   logic [REQ_WIDTH-1:0] sel_len;
   logic                 sel_ok;

   // Length of the granted channel; sel_ok is low for an out-of-range index.
   always_comb begin
      sel_len = '0;
      sel_ok  = 1'b0;
      for (int i = 0; i < int'(CH_NUM); i++) begin
         if (grant_i == CH_W'(i)) begin
            sel_len = req_i[i];
            sel_ok  = 1'b1;
         end
      end
   end

   // Dispatcher FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         busy_o       <= 1'b0;
         cmd_valid_o  <= 1'b0;
         cmd_ch_o     <= '0;
         cmd_len_o    <= '0;
         beat_ready_o <= 1'b0;
         beat_last_o  <= 1'b0;
         done_o       <= '0;
         err_o        <= 1'b0;
      end else begin
         done_o <= '0;
         err_o  <= 1'b0;
         if (clear) begin
            state        <= IDLE;
            cnt          <= '0;
            busy_o       <= 1'b0;
            cmd_valid_o  <= 1'b0;
            beat_ready_o <= 1'b0;
            beat_last_o  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (grant_valid_i) begin
                     if (sel_ok && (sel_len != '0)) begin
                        state       <= CMD;
                        busy_o      <= 1'b1;
                        cmd_valid_o <= 1'b1;
                        cmd_ch_o    <= grant_i;
                        cmd_len_o   <= sel_len;
                     end else begin
                        err_o <= 1'b1;
                     end
                  end
               end
               CMD: begin
                  if (cmd_ready_i) begin
                     state        <= DATA;
                     cmd_valid_o  <= 1'b0;
                     beat_ready_o <= 1'b1;
                     beat_last_o  <= (cmd_len_o == REQ_WIDTH'(1));
                     cnt          <= cmd_len_o;
                  end
               end
               DATA: begin
                  if (beat_valid_i) begin
                     cnt <= cnt - REQ_WIDTH'(1);
                     if (cnt == REQ_WIDTH'(1)) begin
                        state        <= DONE;
                        beat_ready_o <= 1'b0;
                        beat_last_o  <= 1'b0;
                        done_o       <= CH_NUM'(1) << cmd_ch_o;
                     end else begin
                        // flag goes high while the final beat is on offer
                        beat_last_o <= (cnt == REQ_WIDTH'(2));
                     end
                  end
               end
               DONE: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_artec_dma_ch_dispatch.sv
// Self-checking bench for artec_dma_ch_dispatch: directed scenarios plus
// randomized transactions, checked by a queue-based scoreboard.
module tb_artec_dma_ch_dispatch;

   localparam int unsigned CH_NUM = artec_dma_pkg::PKG_CH_NUM;
   localparam int unsigned RW     = artec_dma_pkg::PKG_REQ_WIDTH;
   localparam int unsigned CW     = $clog2(CH_NUM);
   localparam int          MAXLEN = (1 << RW) - 1;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       clear = 1'b0;
   logic [CW-1:0]              grant_i = '0;
   logic                       grant_valid_i = 1'b0;
   logic [CH_NUM-1:0][RW-1:0]  req_i = '0;
   logic                       busy_o;
   logic                       cmd_valid_o;
   logic                       cmd_ready_i = 1'b0;
   logic [CW-1:0]              cmd_ch_o;
   logic [RW-1:0]              cmd_len_o;
   logic                       beat_valid_i = 1'b0;
   logic                       beat_ready_o;
   logic                       beat_last_o;
   logic [CH_NUM-1:0]          done_o;
   logic                       err_o;

   int errors = 0;
   int checks = 0;

   artec_dma_ch_dispatch #(.CH_NUM(CH_NUM), .REQ_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .grant_i(grant_i), .grant_valid_i(grant_valid_i), .req_i(req_i),
      .busy_o(busy_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
      .cmd_ch_o(cmd_ch_o), .cmd_len_o(cmd_len_o),
      .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o),
      .beat_last_o(beat_last_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef enum logic [1:0] {EV_CMD, EV_BEAT, EV_DONE, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t kind;
      int       ch;
      int       len;
      bit       last;
   } ev_t;

   ev_t exp_q[$];

   function automatic void push_ev(input ev_kind_t k, input int ch, input int len, input bit last);
      ev_t e;
      e.kind = k; e.ch = ch; e.len = len; e.last = last;
      exp_q.push_back(e);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops one expected event per observed DUT event.
   task automatic mon_check(input ev_kind_t k, input int ch, input int len, input bit last, input int done_v);
      ev_t e;
      bit  bad;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d ch=%0d len=%0d last=%0d done=%0d, required no event (t=%0t)",
                  k, ch, len, last, done_v, $time);
         return;
      end
      e = exp_q.pop_front();
      bad = (e.kind != k);
      if (!bad && k == EV_CMD)  bad = (e.ch != ch) || (e.len != len);
      if (!bad && k == EV_BEAT) bad = (e.last != last);
      if (!bad && k == EV_DONE) bad = (done_v != (1 << e.ch));
      if (bad) begin
         errors++;
         $display("FAIL scoreboard: got kind=%0d ch=%0d len=%0d last=%0d done=%0d, required kind=%0d ch=%0d len=%0d last=%0d (t=%0t)",
                  k, ch, len, last, done_v, e.kind, e.ch, e.len, e.last, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (err_o)                      mon_check(EV_ERR, 0, 0, 1'b0, 0);
         if (cmd_valid_o && cmd_ready_i) mon_check(EV_CMD, int'(cmd_ch_o), int'(cmd_len_o), 1'b0, 0);
         if (beat_valid_i && beat_ready_o) mon_check(EV_BEAT, 0, 0, beat_last_o, 0);
         if (done_o != '0)               mon_check(EV_DONE, 0, 0, 1'b0, int'(done_o));
      end
   end

   // One grant-to-completion transaction. abort_after >= 0 clears after that many beats.
   task automatic run_txn(input int ch, input int len, input bit stall, input int hold, input int abort_after);
      logic [CH_NUM-1:0][RW-1:0] r;
      int  beats, cyc, exp_beats;
      bit  hs;
      for (int i = 0; i < int'(CH_NUM); i++) r[i] = RW'($urandom_range(0, MAXLEN));
      r[ch] = RW'(len);
      req_i = r; grant_i = CW'(ch); grant_valid_i = 1'b1;
      exp_beats = (abort_after >= 0) ? abort_after : len;
      if (len == 0) push_ev(EV_ERR, 0, 0, 1'b0);
      else begin
         push_ev(EV_CMD, ch, len, 1'b0);
         for (int b = 0; b < exp_beats; b++) push_ev(EV_BEAT, 0, 0, b == len - 1);
         if (abort_after < 0) push_ev(EV_DONE, ch, 0, 1'b0);
      end
      @(posedge clk); #1;
      grant_valid_i = 1'b0;
      if (len == 0) begin
         chk("err_pulse", err_o, 1);
         chk("err_busy", busy_o, 0);
         chk("err_no_cmd", cmd_valid_o, 0);
         @(posedge clk); #1;
         chk("err_one_cycle", err_o, 0);
         chk("err_still_idle", busy_o, 0);
         return;
      end
      chk("cmd_latency", cmd_valid_o, 1);
      chk("busy_in_cmd", busy_o, 1);
      // command phase with optional hold, stray grants and req_i changes
      cyc = 0; hs = 1'b0;
      while (!hs && cyc < 200) begin
         if (cyc < hold) cmd_ready_i = 1'b0;
         else cmd_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall || hold > 0) begin
            req_i[ch]     = RW'($urandom);
            grant_valid_i = 1'($urandom_range(0, 1));
            grant_i       = CW'($urandom_range(0, CH_NUM - 1));
         end
         @(negedge clk);
         hs = cmd_valid_o && cmd_ready_i;
         if (cyc < hold) begin
            chk("cmd_hold_valid", cmd_valid_o, 1);
            chk("cmd_hold_ch", cmd_ch_o, ch);
            chk("cmd_hold_len", cmd_len_o, len);
         end
         @(posedge clk); #1;
         cyc++;
      end
      cmd_ready_i = 1'b0; grant_valid_i = 1'b0;
      if (!hs) chk("cmd_timeout", 0, 1);
      // data phase
      beats = 0; cyc = 0;
      while (beats < exp_beats && cyc < 2000) begin
         beat_valid_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall) begin
            req_i[ch]     = RW'($urandom);
            grant_valid_i = 1'($urandom_range(0, 1));
            grant_i       = CW'($urandom_range(0, CH_NUM - 1));
         end
         @(negedge clk);
         if (beat_valid_i && beat_ready_o) beats++;
         @(posedge clk); #1;
         cyc++;
      end
      beat_valid_i = 1'b0; grant_valid_i = 1'b0;
      if (beats < exp_beats) chk("beat_timeout", beats, exp_beats);
      if (abort_after >= 0) begin
         clear = 1'b1; grant_valid_i = 1'b1; grant_i = CW'(ch);
         @(posedge clk); #1;
         clear = 1'b0; grant_valid_i = 1'b0;
         chk("clear_busy", busy_o, 0);
         chk("clear_beat_ready", beat_ready_o, 0);
         chk("clear_done", done_o, 0);
         chk("clear_err", err_o, 0);
         @(posedge clk); #1;
         chk("clear_done_after", done_o, 0);
         chk("clear_busy_after", busy_o, 0);
         return;
      end
      chk("done_busy", busy_o, 1);
      chk("done_onehot", done_o, 1 << ch);
      chk("done_beat_ready", beat_ready_o, 0);
      chk("done_beat_last", beat_last_o, 0);
      if (stall) begin
         grant_valid_i = 1'b1;
         grant_i = CW'($urandom_range(0, CH_NUM - 1));
      end
      @(posedge clk); #1;
      grant_valid_i = 1'b0;
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      chk("idle_err", err_o, 0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"}, busy_o, 0);
      chk({name, "_cmd_valid"}, cmd_valid_o, 0);
      chk({name, "_cmd_ch"}, cmd_ch_o, 0);
      chk({name, "_cmd_len"}, cmd_len_o, 0);
      chk({name, "_beat_ready"}, beat_ready_o, 0);
      chk({name, "_beat_last"}, beat_last_o, 0);
      chk({name, "_done"}, done_o, 0);
      chk({name, "_err"}, err_o, 0);
   endtask

   initial begin
      #1;
      chk_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // basic burst: ch2, length 3, no stalls
      run_txn(2, 3, 1'b0, 0, -1);
      // command held off 5 cycles while req_i[2] changes
      run_txn(2, 3, 1'b0, 5, -1);
      // zero-length grant
      run_txn(1, 0, 1'b0, 0, -1);
      // stray grants during ch0 burst, then ch3 granted right after
      run_txn(0, 5, 1'b1, 0, -1);
      run_txn(3, 2, 1'b0, 0, -1);
      // single-beat burst and maximum-length burst
      run_txn(1, 1, 1'b0, 0, -1);
      run_txn(0, MAXLEN, 1'b1, 0, -1);
      // clear after one of four beats
      run_txn(0, 4, 1'b0, 0, 1);

      // grant in the same cycle as clear is dropped
      req_i = '0; req_i[1] = RW'(5);
      grant_i = CW'(1); grant_valid_i = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; grant_valid_i = 1'b0;
      chk("clear_grant_busy", busy_o, 0);
      chk("clear_grant_cmd", cmd_valid_o, 0);
      grant_i = CW'(0); grant_valid_i = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; grant_valid_i = 1'b0;
      chk("clear_zero_grant_err", err_o, 0);

      // asynchronous reset in the middle of CMD
      req_i[2] = RW'(3); grant_i = CW'(2); grant_valid_i = 1'b1; cmd_ready_i = 1'b0;
      @(posedge clk); #1;
      grant_valid_i = 1'b0;
      chk("pre_rst_cmd_valid", cmd_valid_o, 1);
      #2 rst = 1'b1;
      #1;
      chk_all_zero("mid_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      // first grant after reset is taken on the first edge
      run_txn(2, 3, 1'b0, 0, -1);

      // randomized transactions
      for (int n = 0; n < 40; n++) begin
         int ch, len;
         ch  = $urandom_range(0, CH_NUM - 1);
         len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, MAXLEN);
         run_txn(ch, len, 1'($urandom_range(0, 1)), $urandom_range(0, 2), -1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
